// File: rtl/ras_stack_if.sv
// Fetch-side RAS bus: control codes and recovery inputs in, predicted target and checkpoint state out.
interface ras_stack_if #(
    parameter int unsigned PTR_W = 3,
    parameter int unsigned AW    = 64
);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic             ras_vld_i;
    logic [1:0]       ras_ctl_i;
    logic [AW-1:0]    ret_addr_i;
    logic             restore_i;
    logic [PTR_W-1:0] restore_ptr_i;
    logic [CNT_W-1:0] restore_cnt_i;
    logic [AW-1:0]    ras_data_o;
    logic             empty_o;
    logic             underflow_o;
    logic [PTR_W-1:0] ckpt_ptr_o;
    logic [CNT_W-1:0] ckpt_cnt_o;

    // Branch decoder / recovery side
    modport master (
        output ras_vld_i, ras_ctl_i, ret_addr_i, restore_i, restore_ptr_i, restore_cnt_i,
        input  ras_data_o, empty_o, underflow_o, ckpt_ptr_o, ckpt_cnt_o
    );

    // Stack side
    modport slave (
        input  ras_vld_i, ras_ctl_i, ret_addr_i, restore_i, restore_ptr_i, restore_cnt_i,
        output ras_data_o, empty_o, underflow_o, ckpt_ptr_o, ckpt_cnt_o
    );
endinterface

// File: rtl/ras_stack.sv
// Return address stack for fetch 1: circular buffer with overwrite-oldest on
// overflow and pointer/occupancy checkpoint restore for mispredict recovery.
module ras_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3,
    parameter int unsigned AW    = 64
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    ras_stack_if.slave   bus
);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        CTL_NONE    = 2'b00,
        CTL_PUSH    = 2'b01,
        CTL_POP     = 2'b10,
        CTL_POPPUSH = 2'b11
    } ras_ctl_e;

    logic [AW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             underflow_q, underflow_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    // Next pointer/occupancy, entry write and underflow flag; restore wins over control
    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        underflow_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = ptr_q;
        if (bus.restore_i) begin
            ptr_d = bus.restore_ptr_i;
            cnt_d = (bus.restore_cnt_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.restore_cnt_i;
        end else if (bus.ras_vld_i) begin
            case (ras_ctl_e'(bus.ras_ctl_i))
                CTL_PUSH: begin
                    ptr_d  = ptr_q + PTR_W'(1);
                    wr_en  = 1'b1;
                    wr_idx = ptr_q + PTR_W'(1);
                    if (cnt_q != CNT_W'(DEPTH)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CTL_POP: begin
                    if (cnt_q != '0) begin
                        ptr_d = ptr_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                CTL_POPPUSH: begin
                    wr_en = 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d       = CNT_W'(1);
                        underflow_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointer, occupancy and underflow pulse registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; reset clears every entry so a later restore never exposes stale data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= bus.ret_addr_i;
        end
    end

    // Prediction and checkpoint outputs reflect the pre-update state
    assign bus.ras_data_o  = (cnt_q != '0) ? mem_q[ptr_q] : '0;
    assign bus.empty_o     = (cnt_q == '0);
    assign bus.underflow_o = underflow_q;
    assign bus.ckpt_ptr_o  = ptr_q;
    assign bus.ckpt_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ras_stack.sv
// Directed and randomized bench for ras_stack against a behavioural stack model.
module tb_ras_stack;
    logic clk;
    logic rst_n;

    ras_stack_if #(.PTR_W(3), .AW(64)) ifc ();

    ras_stack #(.DEPTH(8), .PTR_W(3), .AW(64)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: ring of 8 addresses, top index and occupancy
    logic [63:0] m_mem [8];
    int          m_ptr;
    int          m_cnt;
    bit          m_uf;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 64'd0;
        m_ptr = 0;
        m_cnt = 0;
        m_uf  = 1'b0;
    endtask

    task automatic model_step(input bit rs, input int rp, input int rc,
                              input bit v, input int c, input logic [63:0] a);
        m_uf = 1'b0;
        if (rs) begin
            m_ptr = rp;
            m_cnt = (rc > 8) ? 8 : rc;
        end else if (v) begin
            if (c == 1) begin
                m_ptr = (m_ptr + 1) % 8;
                m_mem[m_ptr] = a;
                if (m_cnt < 8) m_cnt = m_cnt + 1;
            end else if (c == 2) begin
                if (m_cnt > 0) begin
                    m_ptr = (m_ptr + 7) % 8;
                    m_cnt = m_cnt - 1;
                end else begin
                    m_uf = 1'b1;
                end
            end else if (c == 3) begin
                m_mem[m_ptr] = a;
                if (m_cnt == 0) begin
                    m_cnt = 1;
                    m_uf  = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data"}, ifc.ras_data_o, (m_cnt != 0) ? m_mem[m_ptr] : 64'd0);
        check({tag, ".empty"}, 64'(ifc.empty_o), 64'(m_cnt == 0));
        check({tag, ".uf"}, 64'(ifc.underflow_o), 64'(m_uf));
        check({tag, ".ptr"}, 64'(ifc.ckpt_ptr_o), 64'(m_ptr));
        check({tag, ".cnt"}, 64'(ifc.ckpt_cnt_o), 64'(m_cnt));
    endtask

    // One clock of stimulus, then model update and full output check
    task automatic step(input string tag, input bit rs, input int rp, input int rc,
                        input bit v, input int c, input logic [63:0] a);
        ifc.restore_i     = rs;
        ifc.restore_ptr_i = 3'(rp);
        ifc.restore_cnt_i = 4'(rc);
        ifc.ras_vld_i     = v;
        ifc.ras_ctl_i     = 2'(c);
        ifc.ret_addr_i    = a;
        @(posedge clk);
        #1;
        model_step(rs, rp, rc, v, c, a);
        check_model(tag);
    endtask

    task automatic push(input string tag, input logic [63:0] a);
        step(tag, 1'b0, 0, 0, 1'b1, 1, a);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, 0, 0, 1'b1, 2, 64'd0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 0, 1'b0, 0, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp;
        int sc;
        logic [63:0] addr;

        ifc.restore_i     = 1'b0;
        ifc.restore_ptr_i = '0;
        ifc.restore_cnt_i = '0;
        ifc.ras_vld_i     = 1'b0;
        ifc.ras_ctl_i     = '0;
        ifc.ret_addr_i    = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: push three, pop back down to empty
        push("t1.p1", 64'hA1);
        push("t1.p2", 64'hA2);
        push("t1.p3", 64'hA3);
        check("t1.top_a3", ifc.ras_data_o, 64'hA3);
        check("t1.cnt3", 64'(ifc.ckpt_cnt_o), 64'd3);
        pop("t1.q1");
        check("t1.top_a2", ifc.ras_data_o, 64'hA2);
        pop("t1.q2");
        check("t1.top_a1", ifc.ras_data_o, 64'hA1);
        pop("t1.q3");
        check("t1.empty", 64'(ifc.empty_o), 64'd1);
        check("t1.data0", ifc.ras_data_o, 64'd0);

        // 2: overflow by one, oldest entry lost
        for (int i = 0; i < 9; i++) push("t2.push", 64'hB0 + 64'(i));
        check("t2.top_b8", ifc.ras_data_o, 64'hB8);
        check("t2.cnt8", 64'(ifc.ckpt_cnt_o), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("t2.pop_val", ifc.ras_data_o, 64'hB8 - 64'(i));
            pop("t2.pop");
        end
        check("t2.empty", 64'(ifc.empty_o), 64'd1);

        // 3: underflow pulses
        pop("t3.uf_pop");
        check("t3.uf_hi", 64'(ifc.underflow_o), 64'd1);
        idle("t3.uf_clr");
        check("t3.uf_lo", 64'(ifc.underflow_o), 64'd0);
        step("t3.pp_empty", 1'b0, 0, 0, 1'b1, 3, 64'hC0);
        check("t3.top_c", ifc.ras_data_o, 64'hC0);
        check("t3.uf_pp", 64'(ifc.underflow_o), 64'd1);
        idle("t3.idle");
        pop("t3.drain");

        // 4: pop+push replaces top in place
        push("t4.d1", 64'hD1);
        push("t4.d2", 64'hD2);
        step("t4.pp_e", 1'b0, 0, 0, 1'b1, 3, 64'hE0);
        check("t4.top_e", ifc.ras_data_o, 64'hE0);
        check("t4.cnt2", 64'(ifc.ckpt_cnt_o), 64'd2);
        pop("t4.pop");
        check("t4.top_d1", ifc.ras_data_o, 64'hD1);
        pop("t4.drain");

        // 5: checkpoint then restore while a push is presented
        push("t5.f1", 64'hF1);
        sp = m_ptr;
        sc = m_cnt;
        push("t5.f2", 64'hF2);
        push("t5.f3", 64'hF3);
        step("t5.restore", 1'b1, sp, sc, 1'b1, 1, 64'hFF);
        check("t5.top_f1", ifc.ras_data_o, 64'hF1);
        check("t5.cnt1", 64'(ifc.ckpt_cnt_o), 64'd1);

        // Randomized traffic including restores with out-of-range counts
        for (int i = 0; i < 400; i++) begin
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0)
                step("rnd.restore", 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     1'b1, int'($urandom_range(0, 3)), addr);
            else
                step("rnd.op", 1'b0, 0, 0, ($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 3)), addr);
        end

        // 6: asynchronous reset in the middle of a push burst
        push("t6.g1", 64'h61);
        push("t6.g2", 64'h62);
        ifc.ras_vld_i  = 1'b1;
        ifc.ras_ctl_i  = 2'b01;
        ifc.ret_addr_i = 64'h63;
        @(posedge clk);
        #1;
        model_step(1'b0, 0, 0, 1'b1, 1, 64'h63);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("t6.async");
        check("t6.empty", 64'(ifc.empty_o), 64'd1);
        check("t6.data0", ifc.ras_data_o, 64'd0);
        ifc.ras_vld_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle("t6.post");
        step("t6.restore_zero", 1'b1, 5, 3, 1'b0, 0, 64'd0);
        check("t6.mem_cleared", ifc.ras_data_o, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
